cla: RTL and testbench

CLA -- requirements
Module: cla

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_logic.sv | 27 ++
 rtl/cla.sv | 59 +++++
 tb/tb_cla.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the 4-bit carry-lookahead group.
package cla_pkg;
  localparam int   GRP_W   = 4;
  localparam logic OUT_RST = 1'b0;

  // Output bundle order: {C4, C3, C2, C1, G, P}
  localparam int   OUT_W   = GRP_W + 2;
endpackage

// File: rtl/cla_logic.sv
// Flattened two-level carry-lookahead equations for one 4-bit group.
module cla_logic
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] g,
  input  logic [GRP_W-1:0] p,
  input  logic             cin,
  output logic [GRP_W:1]   c,
  output logic             g_grp,
  output logic             p_grp
);

  // Every carry is a sum of products of g/p/cin only; no carry feeds another.
  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
  end

endmodule

// File: rtl/cla.sv
// 4-bit carry-lookahead unit with an optional one-cycle output register.
module cla
  import cla_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic g0,
  input  logic p0,
  input  logic g1,
  input  logic p1,
  input  logic g2,
  input  logic p2,
  input  logic g3,
  input  logic p3,
  input  logic cin,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4,
  output logic G,
  output logic P,
  input  logic clk,
  input  logic rst_n
);

  logic [GRP_W:1]   c_comb;
  logic             g_comb;
  logic             p_comb;
  logic [OUT_W-1:0] comb_out;
  logic [OUT_W-1:0] out_vec;

  cla_logic u_logic (
    .g     ({g3, g2, g1, g0}),
    .p     ({p3, p2, p1, p0}),
    .cin   (cin),
    .c     (c_comb),
    .g_grp (g_comb),
    .p_grp (p_comb)
  );

  assign comb_out = {c_comb, g_comb, p_comb};

  // No handshake: a new input set is accepted every cycle, results stream out.
  generate
    if (OUT_REG) begin : g_reg
      logic [OUT_W-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= {OUT_W{OUT_RST}};
        else        out_q <= comb_out;
      end
      assign out_vec = out_q;
    end else begin : g_comb_out
      assign out_vec = comb_out;
    end
  endgenerate

  assign {C4, C3, C2, C1, G, P} = out_vec;

endmodule

// File: tb/tb_cla.sv
// Bench for cla (OUT_REG=1): per-cycle model compare plus literal anchors.
module tb_cla;

  logic clk;
  logic rst_n;
  logic g0, p0, g1, p1, g2, p2, g3, p3, cin;
  logic C1, C2, C3, C4, G, P;
  logic [5:0] dut_out;
  logic [5:0] exp_q[$];
  logic       check_en;
  int         n_checks;
  int         n_fail;

  cla #(.OUT_REG(1'b1)) dut (
    .g0(g0), .p0(p0), .g1(g1), .p1(p1), .g2(g2), .p2(p2), .g3(g3), .p3(p3),
    .cin(cin),
    .C1(C1), .C2(C2), .C3(C3), .C4(C4), .G(G), .P(P),
    .clk(clk), .rst_n(rst_n)
  );

  assign dut_out = {C4, C3, C2, C1, G, P};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got time %0t, required < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Carries follow the adder definition: carry out of bit i is produced when
  // bit i generates, or propagates the carry that arrived into it.
  function automatic logic [5:0] model(input logic [3:0] g, input logic [3:0] p,
                                       input logic ci);
    logic [4:0] c;
    logic       grp_g;
    c[0]  = ci;
    grp_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      grp_g  = g[i] | (p[i] & grp_g);
    end
    return {c[4:1], grp_g, &p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] g, input logic [3:0] p, input logic ci);
    {g3, g2, g1, g0} = g;
    {p3, p2, p1, p0} = p;
    cin = ci;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Drive on the cycle after an edge, check one edge later against a literal;
  // the model is checked against the same literal to pin it.
  task automatic lit(input string name, input logic [3:0] g, input logic [3:0] p,
                     input logic ci, input logic [5:0] exp);
    @(posedge clk); #1;
    drive(g, p, ci);
    @(posedge clk); #1;
    check(name, dut_out, exp);
    check({name, "_model"}, model(g, p, ci), exp);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (check_en)
      exp_q.push_back(rst_n ? model({g3, g2, g1, g0}, {p3, p2, p1, p0}, cin) : 6'b0);
  end

  always @(negedge clk) begin
    logic [5:0] e;
    if (check_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = 6'b0;
      check("cycle", dut_out, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out, 6'b0);
    check_en = 1'b1;
    rst_n    = 1'b1;

    // Literal anchors: {C4,C3,C2,C1,G,P}
    lit("test1",        4'b1001, 4'b1100, 1'b0, 6'b1001_10);
    lit("test2",        4'b1101, 4'b1010, 1'b0, 6'b1111_10);
    lit("prop_cin1",    4'b0000, 4'b1111, 1'b1, 6'b1111_01);
    lit("prop_cin0",    4'b0000, 4'b1111, 1'b0, 6'b0000_01);
    lit("all_zero",     4'b0000, 4'b0000, 1'b0, 6'b0000_00);
    lit("gp_both",      4'b1111, 4'b1111, 1'b0, 6'b1111_11);
    lit("g0_only_ripl", 4'b0001, 4'b1110, 1'b0, 6'b1111_10);

    // Latency: new inputs must not show before the next edge.
    @(posedge clk); #1;
    drive(4'b1001, 4'b1100, 1'b0);
    @(posedge clk); #1;
    drive(4'b1101, 4'b1010, 1'b0);
    #1;
    check("latency_hold", dut_out, 6'b1001_10);
    @(posedge clk); #1;
    check("latency_update", dut_out, 6'b1111_10);

    // Exhaustive sweep of all 512 input combinations.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      @(posedge clk); #1;
      v = 9'(i);
      drive(v[8:5], v[4:1], v[0]);
    end

    // Asynchronous reset mid-stream, then release.
    @(posedge clk); #1;
    drive(4'b1111, 4'b0000, 1'b1);
    @(posedge clk); #2;
    check("pre_reset", dut_out, 6'b1111_10);
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out, 6'b0);
    @(posedge clk); #1;
    check("reset_held", dut_out, 6'b0);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", dut_out, 6'b0);
    @(posedge clk); #1;
    check("release_load", dut_out, 6'b1111_10);

    // Randomised stream with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;

    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check_count: got %0d, required >= 12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
